clk_by_15: RTL and testbench
============================

CLK_BY_15 -- requirements
Module: clk_by_15

Interface
REQ-001 Parameters: none; division ratio fixed at 15.
REQ-002 clk  input  1  system clock; all state updates on this clock, rising-edge and falling-edge registers both clocked by it.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the clock edge of each register; no asynchronous reset path.
REQ-004 clk_out  output  1  divided clock, frequency clk/15, 50% duty cycle.

Function
REQ-005 Internal state SHALL be a 4-bit modulo-15 counter cnt (0..14), a rising-edge register p and a falling-edge register n.
REQ-006 On each rising clk edge with rst low, cnt SHALL advance by 1, wrapping from 14 to 0; values 15 SHALL never occur (if reached by upset, next value SHALL be 0).
REQ-007 On each rising edge with rst low, p SHALL load 1 when the new cnt value is 0..6, else 0; p is high for 7 clk cycles and low for 8.
REQ-008 On each falling clk edge with rst low, n SHALL load the current p (half-cycle-delayed copy of p).
REQ-009 clk_out SHALL equal p OR n, driven from registers only; no other combinational logic on the output path.
REQ-010 Resulting clk_out SHALL be high for exactly 7.5 clk periods and low for 7.5 clk periods, period exactly 15 clk periods.
REQ-011 clk_out rising edges SHALL coincide with the rising clk edge on which cnt becomes 0; falling edges SHALL coincide with the falling clk edge following the rising edge on which cnt becomes 7.
REQ-012 clk_out SHALL be glitch-free: exactly one rising and one falling transition per output period.
REQ-013 Division SHALL be exact in steady state; no drift or cycle slip across the wrap 14->0.

Reset
REQ-014 On a rising edge with rst high: cnt SHALL load 14, p SHALL load 0.
REQ-015 On a falling edge with rst high: n SHALL load 0.
REQ-016 clk_out SHALL be 0 from the first falling edge after rst is sampled high, and SHALL stay 0 while rst remains high.
REQ-017 Reset asserted mid-operation SHALL override counting immediately at the next edge; clk_out may remain high for at most half a clk period after the rising edge that samples rst (until n clears).
REQ-018 First rising edge with rst low after reset SHALL set cnt=0, p=1, so clk_out rises on that edge; output phase is thereby deterministic relative to reset release.
REQ-019 Before the first reset, outputs are unspecified; the bench SHALL apply reset for at least one full clk period before checking.

Verification
REQ-020 Reset hold: clk period 10 ns, rst high for 3 rising edges -> clk_out=0 from first falling edge in reset until release; cnt=14.
REQ-021 Release: rst deasserted before rising edge T -> clk_out rises at T, falls at T+75 ns, rises again at T+150 ns.
REQ-022 Steady state: run 1000 ns after release -> every clk_out high interval 75 ns, every low interval 75 ns, 6 full periods counted with no glitches.
REQ-023 Mid-operation reset: assert rst while clk_out high (cnt=3) for one cycle -> clk_out low within 5 ns after sampling edge; after release clk_out rises on first rising edge with rst low.
REQ-024 Reset during low phase (cnt=10) -> clk_out stays 0, cnt=14 after sampling edge, restarts period cleanly at release.
REQ-025 Wrap check: monitor cnt across 14->0 for 5 periods -> sequence 0..14 repeats, p high exactly for cnt 0..6.

Source files
------------

// File: rtl/clk_by_15_if.sv
// Output bundle of the divide-by-15 clock generator: the divided clock plus
// its internal state (counter, rising-edge and falling-edge phase registers).
`timescale 1ns/1ps
interface clk_by_15_if;
  logic       clk_out;
  logic [3:0] cnt;
  logic       p;
  logic       n;

  modport master (output clk_out, cnt, p, n);
  modport slave  (input  clk_out, cnt, p, n);
endinterface

// File: rtl/clk_by_15.sv
// Divide-by-15 clock with 50% duty: a rising-edge phase p (7 cycles high)
// ORed with a half-cycle-delayed copy n stretches the high time to 7.5 cycles.
`timescale 1ns/1ps
module clk_by_15 (
  input  logic         clk,
  input  logic         rst,
  clk_by_15_if.master  bus
);

  localparam logic [3:0] CNT_LAST   = 4'd14;
  localparam logic [3:0] P_HIGH_MAX = 4'd6;

  logic [3:0] cnt_q;
  logic [3:0] cnt_next;
  logic       p_q;
  logic       n_q;

  // Any count at or above 14 (including an upset to 15) wraps to 0.
  always_comb begin
    cnt_next = cnt_q + 4'd1;
    if (cnt_q >= CNT_LAST) cnt_next = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_LAST;
      p_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      p_q   <= (cnt_next <= P_HIGH_MAX);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) n_q <= 1'b0;
    else     n_q <= p_q;
  end

  assign bus.clk_out = p_q | n_q;
  assign bus.cnt     = cnt_q;
  assign bus.p       = p_q;
  assign bus.n       = n_q;

endmodule

// File: tb/tb_clk_by_15.sv
// Directed bench for clk_by_15: reset hold, release phase, steady-state edge
// timing, counter wrap, and resets asserted in the high and low phases.
`timescale 1ns/1ps
module tb_clk_by_15;

  logic clk;
  logic rst;
  clk_by_15_if bus ();

  clk_by_15 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock: 10 ns period, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Transition log of clk_out while enabled.
  bit     mon_en = 1'b0;
  longint tr_t[$];
  logic   tr_v[$];

  always @(bus.clk_out) begin
    if (mon_en) begin
      tr_t.push_back($time);
      tr_v.push_back(bus.clk_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // k counts rising edges since release (k=0 is the edge on which cnt becomes 0).
  // After rise k: clk_out = p_k | n_(k-1); after the following fall: clk_out = p_k.
  task automatic run_span(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      @(posedge clk); #1;
      check("cnt", 32'(bus.cnt), 32'(k % 15));
      check("p", 32'(bus.p), 32'((k % 15) <= 6));
      check("clk_out_rise", 32'(bus.clk_out),
            32'(((k % 15) <= 6) || (k > 0 && ((k - 1) % 15) <= 6)));
      @(negedge clk); #1;
      check("clk_out_fall", 32'(bus.clk_out), 32'((k % 15) <= 6));
    end
  endtask

  longint t_rel;

  initial begin
    rst = 1'b1;

    // Reset hold over three rising edges.
    @(posedge clk); #1;
    check("rst_cnt_0", 32'(bus.cnt), 32'd14);
    check("rst_p_0", 32'(bus.p), 32'd0);
    @(negedge clk); #1;
    check("rst_out_0", 32'(bus.clk_out), 32'd0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_cnt", 32'(bus.cnt), 32'd14);
      check("rst_out_r", 32'(bus.clk_out), 32'd0);
      @(negedge clk); #1;
      check("rst_out_f", 32'(bus.clk_out), 32'd0);
    end

    // Release before the rising edge at 35 ns; log transitions across 7+ periods.
    rst    = 1'b0;
    mon_en = 1'b1;
    t_rel  = 35;
    run_span(0, 108);
    mon_en = 1'b0;

    // Rises at T+150j, falls at T+75+150j, strictly alternating, no glitches.
    check("tr_count", 32'(tr_t.size()), 32'd15);
    for (int i = 0; i < tr_t.size() && i < 15; i++) begin
      check("tr_time", 32'(tr_t[i]), 32'(t_rel + 75 * i));
      check("tr_val", 32'(tr_v[i]), 32'(i % 2 == 0));
    end

    // Mid-operation reset while high (cnt=3): sampled at next rise, low by next fall.
    check("mid_cnt3", 32'(bus.cnt), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cnt", 32'(bus.cnt), 32'd14);
    check("mid_rst_p", 32'(bus.p), 32'd0);
    @(negedge clk); #1;
    check("mid_rst_out", 32'(bus.clk_out), 32'd0);
    rst = 1'b0;
    run_span(0, 10);

    // Reset during low phase (cnt=10): output stays low, cnt reloads 14.
    check("low_cnt10", 32'(bus.cnt), 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("low_rst_cnt", 32'(bus.cnt), 32'd14);
    check("low_rst_out_r", 32'(bus.clk_out), 32'd0);
    @(negedge clk); #1;
    check("low_rst_out_f", 32'(bus.clk_out), 32'd0);
    rst = 1'b0;
    run_span(0, 31);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
